// File: rtl/slave_interface.sv
// slave_interface: serial system-bus slave. It deserialises the address and write-data frames,
//   matches addr[15:12] against SLAVE_ID, does a one-byte access on a local memory port, and
//   returns serial read data plus a 2-bit response on tristate drivers.
// Latency: read takes 31 cycles from the address start bit (18 addr, DECODE, MEM_RD, RD_CAP, 9 RDATA, RESP).
//   Write ends with MEM_WR plus RESP after the last data bit. No backpressure: the master paces the frames.
// Ports: clk, reset (async active-low); from_addr_bus, from_wdata_bus, from_response_bus are bus inputs;
//   to_rdata_bus, to_response_bus are tristate bus outputs; mem_addr, mem_wdata, mem_we, mem_re and
//   mem_rdata form the local memory port; busy is high whenever the FSM is not IDLE.
// Option: define SLAVE_TIMEOUT_EN to abort a write whose data frame does not start within TIMEOUT
//   cycles. The abort answers SLVERR and skips the memory write.
module slave_interface #(
  parameter logic [3:0]  SLAVE_ID  = 4'h1,
  parameter int          MEM_AW    = 12,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              from_addr_bus,
  input  logic              from_wdata_bus,
  input  logic [1:0]        from_response_bus,
  output tri logic          to_rdata_bus,
  output tri logic [1:0]    to_response_bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

`ifdef SLAVE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int         TW          = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    IDLE, ADDR, DECODE, IGNORE, WD_WAIT, WDATA, MEM_WR, MEM_RD, RD_CAP, RDATA, RESP
  } state_t;

  state_t            state;
  logic [4:0]        cnt;
  logic [16:0]       addr_sr;   // {rw, addr[15:0]} once the address frame is complete
  logic [7:0]        data_sr;
  logic [TW-1:0]     wait_cnt;
  logic              rdata_en;
  logic              rdata_bit;
  logic              resp_en;
  logic [1:0]        resp_code;

  logic              is_write;
  logic              hit;
  logic              in_range;
  logic [MEM_AW-1:0] offset;

  // addr_sr stays frozen after ADDR, so these decodes remain valid through the write-data phase.
  assign is_write = addr_sr[16];
  assign hit      = (addr_sr[15:12] == SLAVE_ID);
  assign offset   = addr_sr[MEM_AW-1:0];
  assign in_range = ({{(32-MEM_AW){1'b0}}, offset} < MEM_DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rdata_en  <= 1'b0;
      rdata_bit <= 1'b0;
      resp_en   <= 1'b0;
      resp_code <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (from_addr_bus) begin
            state <= ADDR;
            cnt   <= '0;
          end
        end
        ADDR: begin
          addr_sr <= {addr_sr[15:0], from_addr_bus};
          if (cnt == 5'd16) state <= DECODE;
          else              cnt   <= cnt + 5'd1;
        end
        DECODE: begin
          if (!hit) begin
            state <= IGNORE;
          end else begin
            if (in_range) mem_addr <= offset;
            if (is_write) begin
              state    <= WD_WAIT;
              wait_cnt <= '0;
            end else if (in_range) begin
              state  <= MEM_RD;
              mem_re <= 1'b1;
            end else begin
              state     <= RESP;
              resp_en   <= 1'b1;
              resp_code <= RESP_SLVERR;
            end
          end
        end
        // Another slave owns this transfer; its response on the shared bus marks the end.
        IGNORE: begin
          if (from_response_bus != 2'b00) state <= IDLE;
        end
        WD_WAIT: begin
          if (from_wdata_bus) begin
            state <= WDATA;
            cnt   <= '0;
          end else if (TIMEOUT_EN && (wait_cnt == TW'(TIMEOUT - 1))) begin
            state     <= RESP;
            resp_en   <= 1'b1;
            resp_code <= RESP_SLVERR;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        WDATA: begin
          data_sr <= {data_sr[6:0], from_wdata_bus};
          if (cnt == 5'd7) begin
            if (in_range) begin
              mem_wdata <= {data_sr[6:0], from_wdata_bus};
              mem_we    <= 1'b1;
              state     <= MEM_WR;
            end else begin
              state     <= RESP;
              resp_en   <= 1'b1;
              resp_code <= RESP_SLVERR;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        MEM_WR: begin
          mem_we    <= 1'b0;
          state     <= RESP;
          resp_en   <= 1'b1;
          resp_code <= RESP_OK;
        end
        MEM_RD: begin
          mem_re <= 1'b0;
          state  <= RD_CAP;
        end
        // mem_rdata is valid the cycle after the read strobe.
        RD_CAP: begin
          data_sr   <= mem_rdata;
          rdata_en  <= 1'b1;
          rdata_bit <= 1'b1;   // start bit
          cnt       <= '0;
          state     <= RDATA;
        end
        RDATA: begin
          if (cnt == 5'd8) begin
            rdata_en  <= 1'b0;
            rdata_bit <= 1'b0;
            resp_en   <= 1'b1;
            resp_code <= RESP_OK;
            state     <= RESP;
          end else begin
            rdata_bit <= data_sr[7];
            data_sr   <= {data_sr[6:0], 1'b0};
            cnt       <= cnt + 5'd1;
          end
        end
        RESP: begin
          resp_en   <= 1'b0;
          resp_code <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign to_rdata_bus    = rdata_en ? rdata_bit : 1'bz;
  assign to_response_bus = resp_en  ? resp_code : 2'bzz;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_slave_interface.sv
// tb_slave_interface: randomized bench for slave_interface. It builds a cycle-by-cycle plan of
//   bus inputs and expected observations for each transfer from the frame-level rules. A small
//   local memory model answers mem_re one cycle later.
module tb_slave_interface;
  localparam int          MEM_AW    = 12;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned TIMEOUT   = 64;
  localparam int          MAXL      = 200;

  // Observation vector layout: {busy, we, re, rd_en, rd_line, resp_en, resp_line[1:0]}
  localparam logic [7:0] V_IDLE = 8'h00;
  localparam logic [7:0] V_BUSY = 8'h80;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              from_addr_bus = 1'b0;
  logic              from_wdata_bus = 1'b0;
  logic [1:0]        from_response_bus = 2'b00;
  wire               to_rdata_bus;
  wire  [1:0]        to_response_bus;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata = 8'h00;
  logic              busy;

  slave_interface #(
    .SLAVE_ID (4'h1),
    .MEM_AW   (MEM_AW),
    .MEM_DEPTH(MEM_DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .from_addr_bus    (from_addr_bus),
    .from_wdata_bus   (from_wdata_bus),
    .from_response_bus(from_response_bus),
    .to_rdata_bus     (to_rdata_bus),
    .to_response_bus  (to_response_bus),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_re           (mem_re),
    .mem_rdata        (mem_rdata),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference memory behind the local port; the plan updates it on every in-range write.
  logic [7:0]        ref_mem [0:4095];
  logic              rd_pend = 1'b0;
  logic [MEM_AW-1:0] rd_pend_addr;

  // Per-transfer plan
  logic       in_a [MAXL];
  logic       in_w [MAXL];
  logic [1:0] in_r [MAXL];
  logic [7:0] ev   [MAXL];
  logic [MEM_AW-1:0] p_off;
  logic [7:0]        p_dat;
  int                plen;

  function automatic logic [7:0] vec(input logic b, input logic we, input logic re, input logic rde,
                                     input logic rdb, input logic rse, input logic [1:0] rsp);
    return {b, we, re, rde, rdb, rse, rsp};
  endfunction

  function automatic logic [7:0] observe();
    return {busy, mem_we, mem_re, dut.rdata_en, to_rdata_bus === 1'b1, dut.resp_en,
            to_response_bus[1] === 1'b1, to_response_bus[0] === 1'b1};
  endfunction

  // Index 0 is the cycle whose rising edge samples the address start bit.
  // ev[t] holds the outputs expected just after that t-th edge.
  task automatic plan(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                      input int gap, input bit no_data);
    logic [MEM_AW-1:0] off;
    logic [7:0]        d;
    bit                hit;
    bit                inr;
    int                w;
    int                r;
    off = addr[MEM_AW-1:0];
    hit = (addr[15:12] == 4'h1);
    inr = (32'(off) < MEM_DEPTH);
    p_off = off;
    p_dat = wd;
    for (int t = 0; t < MAXL; t++) begin
      in_a[t] = 1'b0; in_w[t] = 1'b0; in_r[t] = 2'b00; ev[t] = V_BUSY;
    end
    in_a[0] = 1'b1;
    in_a[1] = wr;
    for (int i = 0; i < 16; i++) in_a[2+i] = addr[15-i];
    // wdata and response activity before the address is decoded must be ignored
    for (int t = 0; t <= 18; t++) begin
      in_w[t] = 1'($urandom);
      if (t > 0) in_r[t] = 2'($urandom);
    end
    if (!hit) begin
      r = 19 + gap;
      for (int t = 19; t <= r; t++) in_a[t] = 1'($urandom);
      in_r[r] = 2'($urandom_range(1, 3));
      ev[r]   = V_IDLE;
      plen    = r + 1;
    end else if (!wr) begin
      if (inr) begin
        d = ref_mem[off];
        p_dat = d;
        ev[18] = vec(1, 0, 1, 0, 0, 0, 2'b00);
        ev[20] = vec(1, 0, 0, 1, 1, 0, 2'b00);
        for (int i = 0; i < 8; i++) ev[21+i] = vec(1, 0, 0, 1, d[7-i], 0, 2'b00);
        ev[29] = vec(1, 0, 0, 0, 0, 1, 2'b01);
        ev[30] = V_IDLE;
        plen   = 31;
      end else begin
        ev[18] = vec(1, 0, 0, 0, 0, 1, 2'b10);
        ev[19] = V_IDLE;
        plen   = 20;
      end
    end else if (no_data) begin
`ifdef SLAVE_TIMEOUT_EN
      ev[18 + int'(TIMEOUT)] = vec(1, 0, 0, 0, 0, 1, 2'b10);
      ev[19 + int'(TIMEOUT)] = V_IDLE;
      plen = 20 + int'(TIMEOUT);
`else
      plen = 18 + int'(TIMEOUT) + 40;
`endif
    end else begin
      w = 19 + gap;
      in_w[w] = 1'b1;
      for (int i = 0; i < 8; i++) in_w[w+1+i] = wd[7-i];
      if (inr) begin
        ev[w+8]  = vec(1, 1, 0, 0, 0, 0, 2'b00);
        ev[w+9]  = vec(1, 0, 0, 0, 0, 1, 2'b01);
        ev[w+10] = V_IDLE;
        plen     = w + 11;
        ref_mem[off] = wd;
      end else begin
        ev[w+8] = vec(1, 0, 0, 0, 0, 1, 2'b10);
        ev[w+9] = V_IDLE;
        plen    = w + 10;
      end
    end
  endtask

  task automatic mem_model();
    if (rd_pend) begin
      mem_rdata = ref_mem[rd_pend_addr];
      rd_pend   = 1'b0;
    end else begin
      mem_rdata = 8'($urandom);
    end
    if (mem_re === 1'b1) begin
      rd_pend      = 1'b1;
      rd_pend_addr = mem_addr;
    end
  endtask

  task automatic run_plan(input string name, input int upto);
    for (int t = 0; t < upto; t++) begin
      from_addr_bus     = in_a[t];
      from_wdata_bus    = in_w[t];
      from_response_bus = in_r[t];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s bus t=%0d", name, t), 32'(observe()), 32'(ev[t]));
      if (ev[t][6]) begin
        chk($sformatf("%s wr_addr", name), 32'(mem_addr), 32'(p_off));
        chk($sformatf("%s wr_data", name), 32'(mem_wdata), 32'(p_dat));
      end
      if (ev[t][5]) chk($sformatf("%s rd_addr", name), 32'(mem_addr), 32'(p_off));
      mem_model();
    end
    from_addr_bus     = 1'b0;
    from_wdata_bus    = 1'b0;
    from_response_bus = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      from_addr_bus     = 1'b0;
      from_wdata_bus    = 1'($urandom);
      from_response_bus = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("idle", 32'(observe()), 32'(V_IDLE));
      mem_model();
    end
    from_wdata_bus    = 1'b0;
    from_response_bus = 2'b00;
  endtask

  logic [15:0] ra;
  bit          rwr;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("reset outputs", 32'(observe()), 32'(V_IDLE));
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Write then read at offset 0x034
    plan(1'b1, 16'h1034, 8'hA5, 2, 1'b0);
    run_plan("t1_write", plen);
    ref_mem[12'h034] = 8'h5A;
    plan(1'b0, 16'h1034, 8'h00, 0, 1'b0);
    run_plan("t2_read", plen);
    idle(1);

    // Offset beyond MEM_DEPTH: SLVERR without memory strobes
    plan(1'b0, 16'h1100, 8'h00, 0, 1'b0);
    run_plan("t3_rd_oor", plen);
    plan(1'b1, 16'h1100, 8'h3C, 1, 1'b0);
    run_plan("t3_wr_oor", plen);

    // Foreign slave ID, then a frame for this slave
    plan(1'b0, 16'h2034, 8'h00, 6, 1'b0);
    run_plan("t4_ignore", plen);
    plan(1'b0, 16'h1000, 8'h00, 0, 1'b0);
    run_plan("t4_next", plen);

    // Reset in the middle of the read-data shift
    ref_mem[12'h077] = 8'hFF;
    plan(1'b0, 16'h1077, 8'h00, 0, 1'b0);
    run_plan("t5_pre", 25);
    #2 reset = 1'b0;
    #1;
    chk("t5 rdata_en drop", 32'(dut.rdata_en), 32'd0);
    chk("t5 rdata line", 32'(to_rdata_bus === 1'b1), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t5 held", 32'(observe()), 32'(V_IDLE));
    reset = 1'b1;
    plan(1'b1, 16'h1077, 8'hC3, 0, 1'b0);
    run_plan("t5_write", plen);
    plan(1'b0, 16'h1077, 8'h00, 0, 1'b0);
    run_plan("t5_readback", plen);

    // Write address with no data frame
    plan(1'b1, 16'h1010, 8'h00, 0, 1'b1);
    run_plan("t6_nodata", plen);
`ifndef SLAVE_TIMEOUT_EN
    reset = 1'b0;
    #1;
    chk("t6 reset exit", 32'(observe()), 32'(V_IDLE));
    @(negedge clk);
    reset = 1'b1;
`endif
    idle(1);

    // Randomized mix: about a quarter foreign IDs, half of offsets out of range
    for (int k = 0; k < 40; k++) begin
      ra[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1;
      ra[11:0]  = 12'($urandom_range(0, 511));
      rwr       = 1'($urandom);
      plan(rwr, ra, 8'($urandom), int'($urandom_range(0, 6)), 1'b0);
      run_plan($sformatf("rnd%0d", k), plen);
      idle(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
